// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the MM:SS 7-segment counter.
package seg7_pkg;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] bcd_t;

   // Low-true segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [6:0] seg_decode(input bcd_t d);
      case (d)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser followed by a registered rising-edge pulse.
// The pulse is one cycle wide and appears 3 clk cycles after the input rises.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic pulse
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;
   logic pulse_q, pulse_d;

   // Next-state: shift through the synchroniser, flag a 0->1 transition
   always_comb begin
      s1_d    = d_in;
      s2_d    = s1_q;
      prev_d  = s2_q;
      pulse_d = s2_q & ~prev_q;
   end

   // State registers; prev resets to 0 so a level already high at release yields one pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/seg7_mmss_counter.sv
// BCD MM:SS counter driving a 4-digit multiplexed common-anode 7-segment display.
// clk_hz / clk_khz are sampled as data in the clki domain.
// Optional macro SEG7_MMSS_BLANK_EN enables leading-zero blanking of the minute digits.
module seg7_mmss_counter
   import seg7_pkg::*;
#(
   parameter int unsigned MIN_LIMIT      = 59,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clki,
   input  logic       rst_n,
   input  logic       clk_hz,
   input  logic       clk_khz,
   input  logic       run,
   input  logic       clr,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       wrap
);

   localparam bcd_t LIM_TENS = bcd_t'(MIN_LIMIT / 10);
   localparam bcd_t LIM_ONES = bcd_t'(MIN_LIMIT % 10);
   localparam logic INACT    = SEG_ACTIVE_LOW;

   logic sec_tick;
   logic scan_tick;

   bcd_t sec_ones_q, sec_ones_d;
   bcd_t sec_tens_q, sec_tens_d;
   bcd_t min_ones_q, min_ones_d;
   bcd_t min_tens_q, min_tens_d;
   logic wrap_q, wrap_d;

   digit_idx_t idx_q, idx_d;
   logic [3:0] an_q, an_d;
   logic [6:0] seg_q, seg_d;
   logic       dp_q, dp_d;

   bcd_t       sel;
   logic [3:0] an_lt;
   logic [6:0] seg_lt;
   logic       dp_lt;
   logic       blank;

   sync_edge_det u_sync_hz (
      .clk   (clki),
      .rst_n (rst_n),
      .d_in  (clk_hz),
      .pulse (sec_tick)
   );

   sync_edge_det u_sync_khz (
      .clk   (clki),
      .rst_n (rst_n),
      .d_in  (clk_khz),
      .pulse (scan_tick)
   );

   // Time count: clear beats tick; tick advances only when run is high
   always_comb begin
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      wrap_d     = 1'b0;
      if (clr) begin
         sec_ones_d = '0;
         sec_tens_d = '0;
         min_ones_d = '0;
         min_tens_d = '0;
      end else if (sec_tick && run) begin
         if (sec_ones_q != 4'd9) begin
            sec_ones_d = sec_ones_q + 1'b1;
         end else begin
            sec_ones_d = '0;
            if (sec_tens_q != 4'd5) begin
               sec_tens_d = sec_tens_q + 1'b1;
            end else begin
               sec_tens_d = '0;
               if (min_tens_q == LIM_TENS && min_ones_q == LIM_ONES) begin
                  min_ones_d = '0;
                  min_tens_d = '0;
                  wrap_d     = 1'b1;
               end else if (min_ones_q == 4'd9) begin
                  min_ones_d = '0;
                  min_tens_d = min_tens_q + 1'b1;
               end else begin
                  min_ones_d = min_ones_q + 1'b1;
               end
            end
         end
      end
   end

   // Display scan: on each scan tick, step the index and latch the new digit's drive
   always_comb begin
      idx_d  = idx_q;
      an_d   = an_q;
      seg_d  = seg_q;
      dp_d   = dp_q;
      sel    = '0;
      an_lt  = '1;
      seg_lt = SEG_OFF;
      dp_lt  = 1'b1;
      blank  = 1'b0;
      if (scan_tick) begin
         idx_d = idx_q + 1'b1;
         case (idx_d)
            2'd0:    sel = sec_ones_q;
            2'd1:    sel = sec_tens_q;
            2'd2:    sel = min_ones_q;
            default: sel = min_tens_q;
         endcase
         an_lt  = ~(4'b0001 << idx_d);
         seg_lt = seg_decode(sel);
         dp_lt  = (idx_d != 2'd2);
`ifdef SEG7_MMSS_BLANK_EN
         blank = ((idx_d == 2'd3) && (min_tens_q == 4'd0)) ||
                 ((idx_d == 2'd2) && (min_tens_q == 4'd0) && (min_ones_q == 4'd0));
`else
         blank = 1'b0;
`endif
         if (blank) begin
            an_lt  = '1;
            seg_lt = SEG_OFF;
            dp_lt  = 1'b1;
         end
         an_d  = SEG_ACTIVE_LOW ? an_lt  : ~an_lt;
         seg_d = SEG_ACTIVE_LOW ? seg_lt : ~seg_lt;
         dp_d  = SEG_ACTIVE_LOW ? dp_lt  : ~dp_lt;
      end
   end

   // Count and wrap registers
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         sec_ones_q <= '0;
         sec_tens_q <= '0;
         min_ones_q <= '0;
         min_tens_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         wrap_q     <= wrap_d;
      end
   end

   // Scan index and display output registers; reset forces every output inactive
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         an_q  <= {4{INACT}};
         seg_q <= {7{INACT}};
         dp_q  <= INACT;
      end else begin
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign seg  = seg_q;
   assign dp   = dp_q;
   assign an   = an_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_mmss_counter.sv
// Scoreboard bench for seg7_mmss_counter: stimulus pushes expected display
// frames and wrap pulses; a monitor pops and compares as the DUT presents them.
module tb_seg7_mmss_counter;

   localparam int unsigned ML = 59;

   logic       clki    = 1'b0;
   logic       rst_n   = 1'b1;
   logic       clk_hz  = 1'b0;
   logic       clk_khz = 1'b0;
   logic       run     = 1'b0;
   logic       clr     = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       wrap;

   seg7_mmss_counter #(.MIN_LIMIT(ML), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clki    (clki),
      .rst_n   (rst_n),
      .clk_hz  (clk_hz),
      .clk_khz (clk_khz),
      .run     (run),
      .clr     (clr),
      .seg     (seg),
      .dp      (dp),
      .an      (an),
      .wrap    (wrap)
   );

   always #5 clki = ~clki;

   int unsigned cyc = 0;
   always @(posedge clki) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      int unsigned cyc;
   } disp_t;

   disp_t       dq[$];
   int unsigned wq[$];
   int          total = 0;
   int          bad   = 0;

   // reference state: elapsed seconds and number of scan steps mod 4
   int unsigned secs = 0;
   int unsigned idx  = 0;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int unsigned digit_of(input int unsigned s, input int unsigned i);
      int unsigned mm, ss;
      mm = s / 60;
      ss = s % 60;
      case (i)
         0:       return ss % 10;
         1:       return ss / 10;
         2:       return mm % 10;
         default: return mm / 10;
      endcase
   endfunction

   function automatic disp_t expect_frame(input int unsigned at);
      disp_t      e;
      logic [3:0] one;
      one   = 4'b0001;
      e.an  = ~(one << idx);
      e.seg = seg_tab[digit_of(secs, idx)];
      e.dp  = (idx == 2) ? 1'b0 : 1'b1;
      e.cyc = at;
      return e;
   endfunction

   // one clk_hz period: rise, (optional clr aligned with the tick cycle), fall
   task automatic hz_tick(input logic run_lvl, input logic with_clr);
      int unsigned k;
      @(negedge clki);
      run    = run_lvl;
      clk_hz = 1'b1;
      k      = cyc;
      if (with_clr) begin
         secs = 0;
      end else if (run_lvl) begin
         secs++;
         if (secs == (ML + 1) * 60) begin
            secs = 0;
            wq.push_back(k + 4);
         end
      end
      repeat (3) @(negedge clki);
      clr    = with_clr;
      clk_hz = 1'b0;
      @(negedge clki);
      clr = 1'b0;
      run = 1'($urandom);
      @(negedge clki);
   endtask

   task automatic scan();
      int unsigned k;
      @(negedge clki);
      clk_khz = 1'b1;
      k       = cyc;
      idx     = (idx + 1) % 4;
      dq.push_back(expect_frame(k + 4));
      repeat (3) @(negedge clki);
      clk_khz = 1'b0;
      repeat (3) @(negedge clki);
   endtask

   task automatic scan4();
      repeat (4) scan();
   endtask

   // monitor: a new digit select means a new frame; wrap pulses checked for timing/width
   logic [3:0] an_last = 4'hF;
   always @(negedge clki) begin
      disp_t       e;
      int unsigned w;
      if (rst_n && an !== an_last && an !== 4'hF) begin
         if (dq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL disp_unexpected: actual an=%b seg=%b dp=%b required none", an, seg, dp);
         end else begin
            e = dq.pop_front();
            check("disp_an",  32'(an),  32'(e.an));
            check("disp_seg", 32'(seg), 32'(e.seg));
            check("disp_dp",  32'(dp),  32'(e.dp));
            check("disp_cyc", cyc,      e.cyc);
         end
      end
      an_last = an;
      if (rst_n && wrap === 1'b1) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wrap_unexpected: actual wrap=1 required 0 (cyc %0d)", cyc);
         end else begin
            w = wq.pop_front();
            check("wrap_cyc", cyc, w);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      clk_khz = 1'b1;            // already high at release -> exactly one scan tick
      #1 rst_n = 1'b0;
      #2;
      check("rst_an",   32'(an),   32'hF);
      check("rst_seg",  32'(seg),  32'h7F);
      check("rst_dp",   32'(dp),   32'h1);
      check("rst_wrap", 32'(wrap), 32'h0);
      repeat (3) @(negedge clki);
      rst_n = 1'b1;
      k     = cyc;
      idx   = 1;
      dq.push_back(expect_frame(k + 4));
      repeat (6) @(negedge clki);
      clk_khz = 1'b0;
      repeat (3) @(negedge clki);

      repeat (10) hz_tick(1'b1, 1'b0);
      scan4();
      repeat (49) hz_tick(1'b1, 1'b0);
      scan4();
      hz_tick(1'b1, 1'b0);
      scan4();

      for (int i = 0; i < 150; i++) begin
         hz_tick(($urandom % 4) != 0, 1'b0);
         if (($urandom % 16) == 0) hz_tick(1'($urandom), 1'b1);
         if (($urandom % 5) == 0) repeat ($urandom_range(1, 4)) scan();
      end

      while (secs != (ML + 1) * 60 - 1) hz_tick(1'b1, 1'b0);
      scan4();
      hz_tick(1'b1, 1'b0);
      scan4();

      while (secs != 7) hz_tick(1'b1, 1'b0);
      hz_tick(1'b1, 1'b1);
      scan4();
      repeat (5) hz_tick(1'b0, 1'b0);
      scan4();

      hz_tick(1'b0, 1'b1);
      repeat (754) hz_tick(1'b1, 1'b0);
      scan4();

      hz_tick(1'b0, 1'b1);
      repeat (330) hz_tick(1'b1, 1'b0);
      scan();
      scan();
      @(negedge clki);
      #2 rst_n = 1'b0;
      #1;
      check("rst2_an",   32'(an),   32'hF);
      check("rst2_seg",  32'(seg),  32'h7F);
      check("rst2_dp",   32'(dp),   32'h1);
      check("rst2_wrap", 32'(wrap), 32'h0);
      secs = 0;
      idx  = 0;
      repeat (3) @(negedge clki);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clki);
         check("blank_after_rst", 32'(an), 32'hF);
      end
      scan4();

      repeat (10) @(negedge clki);
      check("disp_queue_empty", dq.size(), 0);
      check("wrap_queue_empty", wq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
